// File: rtl/miter_pkg.sv
// Shared types and default widths for the lockstep miter comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package miter_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_SETTLE   = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_RUN    = 3'd2,
        S_FAIL   = 3'd3,
        S_DONE   = 3'd4
    } miter_state_e;

endpackage

// File: rtl/miter_chan_cmp.sv
// One gold/gate channel compare: masked XOR and a mismatch flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluates every cycle regardless of valid.
module miter_chan_cmp
    import miter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] gold_i,
    input  logic [WIDTH-1:0] gate_i,
    input  logic [WIDTH-1:0] care_i,
    output logic             mism_o,
    output logic [WIDTH-1:0] diff_o
);

    // Don't-care bits are masked out before the mismatch reduction
    always_comb begin
        diff_o = (gold_i ^ gate_i) & care_i;
        mism_o = |diff_o;
    end

endmodule

// File: rtl/miter_lockstep_cmp.sv
// Lockstep miter: compares gold vs gate channels per valid sample, counts samples/mismatches, flags sticky fail.
// Latency: one cycle from a valid sample to fail, sample_cnt and mism_cnt.
// Backpressure: none; every valid sample is consumed. Build option MITER_FIRST_FAIL_CAPTURE_EN adds first-fail capture.
module miter_lockstep_cmp
    import miter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SETTLE   = DEF_SETTLE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_gold,
    input  logic [CHANNELS*WIDTH-1:0] in_gate,
    input  logic [CHANNELS*WIDTH-1:0] in_care,
    output logic                      busy,
    output logic                      fail,
    output logic                      done,
    output logic [CNT_W-1:0]          sample_cnt,
    output logic [CNT_W-1:0]          mism_cnt
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
    ,
    output logic [CNT_W-1:0]          ff_index,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ff_chan,
    output logic [WIDTH-1:0]          ff_diff
`endif
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = $clog2(SETTLE + 2);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    miter_state_e               state_q, state_d;
    logic [SW-1:0]              settle_q, settle_d;
    logic [CNT_W-1:0]           sample_q, sample_d;
    logic [CNT_W-1:0]           mism_q, mism_d;
    logic [CHANNELS-1:0]        mism_vec;
    logic [CHANNELS*WIDTH-1:0]  diff_flat;
    logic                       any_mism;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        miter_chan_cmp #(.WIDTH(WIDTH)) u_cmp (
            .gold_i (in_gold[g*WIDTH +: WIDTH]),
            .gate_i (in_gate[g*WIDTH +: WIDTH]),
            .care_i (in_care[g*WIDTH +: WIDTH]),
            .mism_o (mism_vec[g]),
            .diff_o (diff_flat[g*WIDTH +: WIDTH])
        );
    end

    assign any_mism = |mism_vec;

`ifdef MITER_FIRST_FAIL_CAPTURE_EN
    logic [CNT_W-1:0] ff_index_q, ff_index_d;
    logic [CW-1:0]    ff_chan_q, ff_chan_d;
    logic [WIDTH-1:0] ff_diff_q, ff_diff_d;
`else
    // Per-channel diffs only feed the capture logic, which is not built here
    logic unused_diff;
    assign unused_diff = ^diff_flat;
`endif

    // Next-state and counter update; start overrides everything except reset
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        sample_d = sample_q;
        mism_d   = mism_q;
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        ff_index_d = ff_index_q;
        ff_chan_d  = ff_chan_q;
        ff_diff_d  = ff_diff_q;
`endif
        if (start) begin
            sample_d = '0;
            mism_d   = '0;
            settle_d = '0;
            state_d  = (SETTLE == 0) ? S_RUN : S_SETTLE;
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
            ff_index_d = '0;
            ff_chan_d  = '0;
            ff_diff_d  = '0;
`endif
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (in_valid) begin
                        if (settle_q == SETTLE_LAST) begin
                            state_d = S_RUN;
                        end else begin
                            settle_d = settle_q + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        sample_d = sat_inc(sample_q);
                        if (any_mism) begin
                            mism_d  = sat_inc(mism_q);
                            state_d = S_FAIL;
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
                            ff_index_d = sat_inc(sample_q);
                            for (int i = CHANNELS - 1; i >= 0; i--) begin
                                if (mism_vec[i]) begin
                                    ff_chan_d = CW'(i);
                                    ff_diff_d = diff_flat[i*WIDTH +: WIDTH];
                                end
                            end
`endif
                        end
                    end
                    // A mismatch on the stop cycle still reports as a failure
                    if (stop && (state_d != S_FAIL)) begin
                        state_d = S_DONE;
                    end
                end
                S_FAIL: begin
                    if (in_valid) begin
                        sample_d = sat_inc(sample_q);
                        if (any_mism) begin
                            mism_d = sat_inc(mism_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            sample_q <= '0;
            mism_q   <= '0;
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
            ff_index_q <= '0;
            ff_chan_q  <= '0;
            ff_diff_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            sample_q <= sample_d;
            mism_q   <= mism_d;
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
            ff_index_q <= ff_index_d;
            ff_chan_q  <= ff_chan_d;
            ff_diff_q  <= ff_diff_d;
`endif
        end
    end

    // Status flags decode directly from the registered state
    always_comb begin
        busy       = (state_q == S_SETTLE) || (state_q == S_RUN);
        fail       = (state_q == S_FAIL);
        done       = (state_q == S_DONE);
        sample_cnt = sample_q;
        mism_cnt   = mism_q;
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        ff_index   = ff_index_q;
        ff_chan    = ff_chan_q;
        ff_diff    = ff_diff_q;
`endif
    end

endmodule

// File: tb/tb_miter_lockstep_cmp.sv
// Directed self-checking bench for miter_lockstep_cmp (default and CNT_W=4 instances).
// Latency: checks outputs #1 after the edge that consumed each sample.
// Backpressure: n/a; stimulus is driven every cycle.
module tb_miter_lockstep_cmp;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        in_valid;
    logic [31:0] in_gold;
    logic [31:0] in_gate;
    logic [31:0] in_care;

    logic        busy, fail, done;
    logic [15:0] sample_cnt, mism_cnt;
    logic        s_busy, s_fail, s_done;
    logic [3:0]  s_sample_cnt, s_mism_cnt;
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
    logic [15:0] ff_index;
    logic [1:0]  ff_chan;
    logic [7:0]  ff_diff;
    logic [3:0]  s_ff_index;
    logic [1:0]  s_ff_chan;
    logic [7:0]  s_ff_diff;
`endif

    int checks   = 0;
    int failures = 0;

    miter_lockstep_cmp u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_gold    (in_gold),
        .in_gate    (in_gate),
        .in_care    (in_care),
        .busy       (busy),
        .fail       (fail),
        .done       (done),
        .sample_cnt (sample_cnt),
        .mism_cnt   (mism_cnt)
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        ,
        .ff_index   (ff_index),
        .ff_chan    (ff_chan),
        .ff_diff    (ff_diff)
`endif
    );

    miter_lockstep_cmp #(.CNT_W(4)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_gold    (in_gold),
        .in_gate    (in_gate),
        .in_care    (in_care),
        .busy       (s_busy),
        .fail       (s_fail),
        .done       (s_done),
        .sample_cnt (s_sample_cnt),
        .mism_cnt   (s_mism_cnt)
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        ,
        .ff_index   (s_ff_index),
        .ff_chan    (s_ff_chan),
        .ff_diff    (s_ff_diff)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [31:0] g, input logic [31:0] t, input logic [31:0] c);
        in_valid = 1'b1;
        in_gold  = g;
        in_gate  = t;
        in_care  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Start a run and push the two settle samples through
    task automatic start_and_settle();
        pulse_start();
        sample(32'h0, 32'h0, 32'hFFFF_FFFF);
        sample(32'h0, 32'h0, 32'hFFFF_FFFF);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        in_gold = '0; in_gate = '0; in_care = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fail", fail, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sample", sample_cnt, 0);
        check_eq("rst_mism", mism_cnt, 0);
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        check_eq("rst_ff_index", ff_index, 0);
        check_eq("rst_ff_chan", ff_chan, 0);
        check_eq("rst_ff_diff", ff_diff, 0);
`endif

        // Clean run: 10 equal samples, first two are settle samples
        pulse_start();
        check_eq("clean_busy_settle", busy, 1);
        for (int i = 0; i < 10; i++) begin
            sample(32'h1234_5678 + i, 32'h1234_5678 + i, 32'hFFFF_FFFF);
            if (i == 1) check_eq("clean_settle_uncounted", sample_cnt, 0);
            if (i == 2) check_eq("clean_first_count", sample_cnt, 1);
        end
        tick(); tick();
        check_eq("clean_idle_valid_hold", sample_cnt, 8);
        stop = 1'b1; tick(); stop = 1'b0;
        check_eq("clean_done", done, 1);
        check_eq("clean_busy", busy, 0);
        check_eq("clean_fail", fail, 0);
        check_eq("clean_sample", sample_cnt, 8);
        check_eq("clean_mism", mism_cnt, 0);
        sample(32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF);
        check_eq("done_ignores_sample", sample_cnt, 8);
        check_eq("done_ignores_fail", fail, 0);

        // Stop during settle returns to idle without done
        pulse_start();
        sample(32'h0, 32'h0, 32'hFFFF_FFFF);
        stop = 1'b1; tick(); stop = 1'b0;
        check_eq("settle_stop_busy", busy, 0);
        check_eq("settle_stop_done", done, 0);

        // Masked mismatch on channel 2; settle-phase mismatch is not compared
        pulse_start();
        sample(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
        sample(32'h0, 32'h0, 32'hFFFF_FFFF);
        check_eq("settle_no_compare", fail, 0);
        sample(32'h11A5_3344, 32'h11A4_3344, 32'hFFFE_FFFF);
        check_eq("masked_fail", fail, 0);
        check_eq("masked_sample", sample_cnt, 1);
        check_eq("masked_mism", mism_cnt, 0);

        // Real mismatch on compared sample 5, channels 1 and 3 differ
        start_and_settle();
        for (int i = 0; i < 4; i++) sample(32'hAABB_CCDD, 32'hAABB_CCDD, 32'hFFFF_FFFF);
        check_eq("pre_mism_fail", fail, 0);
        sample(32'hAABB_CCDD, 32'h2ABB_C3DD, 32'hFFFF_F3FF);
        check_eq("mism_fail", fail, 1);
        check_eq("mism_cnt", mism_cnt, 1);
        check_eq("mism_sample", sample_cnt, 5);
        check_eq("mism_busy", busy, 0);
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        check_eq("ff_index", ff_index, 5);
        check_eq("ff_chan", ff_chan, 1);
        check_eq("ff_diff", ff_diff, 8'h03);
`endif
        sample(32'h1, 32'h1, 32'hFFFF_FFFF);
        sample(32'h1, 32'h1, 32'hFFFF_FFFF);
        sample(32'h1, 32'h0, 32'hFFFF_FFFF);
        check_eq("failst_sample", sample_cnt, 8);
        check_eq("failst_mism", mism_cnt, 2);
        check_eq("failst_hold", fail, 1);
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        check_eq("ff_index_hold", ff_index, 5);
`endif

        // Start and stop together during RUN: start wins, back to settle
        start_and_settle();
        for (int i = 0; i < 3; i++) sample(32'h5, 32'h5, 32'hFFFF_FFFF);
        check_eq("ss_pre_sample", sample_cnt, 3);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check_eq("ss_sample", sample_cnt, 0);
        check_eq("ss_mism", mism_cnt, 0);
        check_eq("ss_busy", busy, 1);
        check_eq("ss_done", done, 0);
        sample(32'h5, 32'h5, 32'hFFFF_FFFF);
        check_eq("ss_in_settle", sample_cnt, 0);

        // Saturation: 20 mismatching samples
        start_and_settle();
        for (int i = 0; i < 20; i++) sample(32'hFF, 32'h00, 32'hFFFF_FFFF);
        check_eq("sat_mism", s_mism_cnt, 15);
        check_eq("sat_sample", s_sample_cnt, 15);
        check_eq("sat_fail", s_fail, 1);
        check_eq("wide_mism", mism_cnt, 20);
        check_eq("wide_sample", sample_cnt, 20);

        // Reset in FAIL, with start also high: reset wins
        rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
        check_eq("rstf_fail", fail, 0);
        check_eq("rstf_busy", busy, 0);
        check_eq("rstf_done", done, 0);
        check_eq("rstf_sample", sample_cnt, 0);
        check_eq("rstf_mism", mism_cnt, 0);
`ifdef MITER_FIRST_FAIL_CAPTURE_EN
        check_eq("rstf_ff_index", ff_index, 0);
`endif
        start_and_settle();
        sample(32'h7, 32'h7, 32'hFFFF_FFFF);
        check_eq("restart_sample", sample_cnt, 1);
        check_eq("restart_mism", mism_cnt, 0);
        check_eq("restart_fail", fail, 0);
        check_eq("restart_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
